audio_tone_mixer: RTL and testbench
===================================

# audio_tone_mixer

Parametrised multi-voice square-wave tone generator and saturating stereo mixer. It sits between the codec `Audio_Controller` input and output FIFOs. Each cycle it may take one stereo sample from the ADC side, add the sum of up to `NUM_VOICES` independent square-wave voices, clip the result to the sample width, and write it to the DAC side. It supersedes the single-tone, wrap-around adder used in the board-level audio top.

## Interface
- `DATA_W`, 32: signed sample width per channel.
- `NUM_VOICES`, 4: number of independent tone voices; must be at least 1.
- `PERIOD_W`, 19: width of each voice half-period field.
- `AMPLITUDE`, 32'h0FFFFFF0: per-voice magnitude. It is positive and less than 2^(DATA_W-1).

Ports:
- `CLOCK_50`, in, 1: system clock. Only clock in the block.
- `reset`, in, 1: asynchronous, active-high reset.
- `period`, in, NUM_VOICES*PERIOD_W: voice v half-period in bits [v*PERIOD_W +: PERIOD_W]. A value of 0 disables the voice.
- `mode`, in, 2: output mode.
  - 00 passthrough.
  - 01 mix (input plus tones).
  - 10 tones only.
  - 11 mute.
- `clip_clear`, in, 1: clears the sticky `clip` flag.
- `audio_in_available`, in, 1: the ADC FIFO holds a sample.
- `left_channel_audio_in`, in, DATA_W: ADC FIFO head, left channel.
- `right_channel_audio_in`, in, DATA_W: ADC FIFO head, right channel.
- `read_audio_in`, out, 1: one-cycle pop of the ADC FIFO.
- `audio_out_allowed`, in, 1: the DAC FIFO has space.
- `left_channel_audio_out`, out, DATA_W: registered left output sample.
- `right_channel_audio_out`, out, DATA_W: registered right output sample.
- `write_audio_out`, out, 1: one-cycle push to the DAC FIFO.
- `clip`, out, 1: sticky flag; set when any channel saturated.

## Operation
- **Voices.** Each voice has a PERIOD_W-bit counter and a phase bit.
  - Period nonzero: if counter >= period, the counter goes to 0 and the phase toggles. Otherwise the counter increments.
  - Half-period is therefore period+1 cycles.
  - The >= compare makes a period lowered mid-count toggle on the next cycle, with no wrap-around.
- **Disabled voice.** Period 0 holds counter = 0 and phase = 0, and the voice contributes 0.
- **Voice value.** Contribution is +AMPLITUDE when phase is 1 and −AMPLITUDE when phase is 0.
- **Tone sum.** Voice contributions are summed signed at width DATA_W+$clog2(NUM_VOICES)+2, with no intermediate overflow.
- **FSM states:** IDLE, CAPTURE, OUTPUT.
  - **IDLE:** if `audio_in_available` & `audio_out_allowed`, assert `read_audio_in` this cycle. Latch both input channels, `mode` and the current tone sum. Go to CAPTURE.
  - **CAPTURE:** compute per channel:
    - mode 00: in.
    - mode 01: in + tones.
    - mode 10: tones.
    - mode 11: 0.
    - The result is saturated to [−2^(DATA_W-1), 2^(DATA_W-1)−1].
    - Register it into the output sample registers.
    - Set `clip` if either channel saturated. Go to OUTPUT.
  - **OUTPUT:** if `audio_out_allowed`, assert `write_audio_out` for one cycle and go to IDLE. Otherwise hold and wait, with the output registers stable.
- **Mute still handshakes.** Mode 11 still reads and writes, so both FIFOs keep draining.
- **Clip flag.** `clip_clear` takes priority over a same-cycle set; the flag clears.
- **Stable inputs.** Changes to `mode` or `period` never corrupt a sample already captured.

## Timing
- **Reset values:**
  - `read_audio_in` = 0 and `write_audio_out` = 0.
  - Output samples = 0 and `clip` = 0.
  - FSM in IDLE.
  - All voice counters = 0 and phases = 0.
- **Reset mid-operation.** Reset asserted in CAPTURE or OUTPUT discards the pending sample; no write is issued.
- **Read.** `read_audio_in` is combinational from the IDLE state and the two input strobes. The ADC data is sampled in that same cycle.
- **Latency.** Read at cycle T gives the earliest write at T+2, with outputs valid from T+2 onward.
- **Throughput.** At most one sample per 3 cycles.
- **Backpressure.** `read_audio_in` never asserts while a sample is pending.
- **Strobes.** `read_audio_in` and `write_audio_out` are never high in the same cycle, and each is high for exactly one cycle per sample.
- **Tone sum timing.** The captured tone sum is the value in the read cycle, before that cycle's counter update.
- **Voice frequency.** f = 50 MHz / (2*(period+1)).

## Test plan
- **Reset.** Assert reset with stimulus active → all outputs 0, no strobes. After release with `audio_in_available` = `audio_out_allowed` = 1 → first `read_audio_in` in the first cycle after release.
- **Passthrough.** Mode 00, all periods 0, input L = 32'h00001234, R = 32'hFFFFFF00 → `write_audio_out` 2 cycles after the read, with out = in; `clip` stays 0.
- **Single voice.** Mode 10, voice 0 period = 3, others 0, input always available → phase toggles every 4 cycles. Output samples alternate between −32'h0FFFFFF0 and +32'h0FFFFFF0 according to the phase at read time.
- **Saturation.** Mode 01, 4 voices with period = 1000 (all in phase 1 after 1001 cycles), input L = 32'h7FFFFFF0, R = 32'h80000010:
  - L → 32'h7FFFFFFF.
  - R with all phases 0 → 32'h80000000.
  - `clip` = 1 until `clip_clear` is pulsed.
- **Backpressure.** Drop `audio_out_allowed` during CAPTURE for 10 cycles → outputs hold and there is no write or read. Raising it gives exactly one `write_audio_out`, then IDLE.
- **Reset mid-sample and period change.** Reset asserted in OUTPUT → no write occurs. Lowering period from 100 to 5 while the counter is at 50 → toggle on the next cycle, then every 6 cycles.

Source files
------------

// File: rtl/audio_tone_mixer.sv
// audio_tone_mixer: multi-voice square-wave generator plus saturating stereo mixer
// between the codec ADC FIFO (read side) and DAC FIFO (write side).
// Latency: read at cycle T, output registered and write strobe at T+2 at the earliest.
// Backpressure: holds the sample in OUTPUT while audio_out_allowed is low; no read while pending.
//
// Ports:
//   CLOCK_50, reset (async, active-high)
//   period     : NUM_VOICES half-period fields, 0 disables a voice
//   mode       : 00 passthrough, 01 mix, 10 tones only, 11 mute
//   clip_clear : clears the sticky clip flag (wins over a same-cycle set)
//   audio_in_available / left/right_channel_audio_in / read_audio_in   : ADC FIFO side
//   audio_out_allowed / left/right_channel_audio_out / write_audio_out : DAC FIFO side
//   clip       : sticky saturation flag
module audio_tone_mixer #(
  parameter int                DATA_W     = 32,
  parameter int                NUM_VOICES = 4,
  parameter int                PERIOD_W   = 19,
  parameter logic [DATA_W-1:0] AMPLITUDE  = 32'h0FFFFFF0
) (
  input  logic                           CLOCK_50,
  input  logic                           reset,
  input  logic [NUM_VOICES*PERIOD_W-1:0] period,
  input  logic [1:0]                     mode,
  input  logic                           clip_clear,
  input  logic                           audio_in_available,
  input  logic [DATA_W-1:0]              left_channel_audio_in,
  input  logic [DATA_W-1:0]              right_channel_audio_in,
  output logic                           read_audio_in,
  input  logic                           audio_out_allowed,
  output logic [DATA_W-1:0]              left_channel_audio_out,
  output logic [DATA_W-1:0]              right_channel_audio_out,
  output logic                           write_audio_out,
  output logic                           clip
);

  // Wide enough that summing every voice plus an input sample never overflows.
  localparam int SUM_W = DATA_W + $clog2(NUM_VOICES) + 2;

  localparam logic [DATA_W-1:0]       MAX_DAT = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0]       MIN_DAT = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-DATA_W){1'b0}}, MAX_DAT};
  localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-DATA_W){1'b1}}, MIN_DAT};
  localparam logic signed [SUM_W-1:0] AMP_POS = {{(SUM_W-DATA_W){1'b0}}, AMPLITUDE};
  localparam logic signed [SUM_W-1:0] AMP_NEG = -AMP_POS;

  typedef enum logic [1:0] {IDLE, CAPTURE, OUTPUT} state_t;

  state_t state, state_nxt;

  // ---------------- voices ----------------
  logic signed [SUM_W-1:0] voice_val [NUM_VOICES];
  logic signed [SUM_W-1:0] tone_sum;

  genvar g;
  generate
    for (g = 0; g < NUM_VOICES; g++) begin : g_voice
      logic [PERIOD_W-1:0] voice_period;
      logic [PERIOD_W-1:0] cnt;
      logic                phase;

      assign voice_period = period[g*PERIOD_W +: PERIOD_W];

      // >= rather than == so a period lowered below the running count
      // toggles on the next cycle instead of wrapping the counter.
      always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
          cnt   <= '0;
          phase <= 1'b0;
        end else if (voice_period == '0) begin
          cnt   <= '0;
          phase <= 1'b0;
        end else if (cnt >= voice_period) begin
          cnt   <= '0;
          phase <= ~phase;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      assign voice_val[g] = (voice_period == '0) ? '0 : (phase ? AMP_POS : AMP_NEG);
    end
  endgenerate

  always_comb begin
    tone_sum = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      tone_sum = tone_sum + voice_val[v];
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    read_audio_in   = 1'b0;
    write_audio_out = 1'b0;
    case (state)
      IDLE: begin
        // Gated by reset so no pop is issued while the block is held in reset.
        if (audio_in_available && audio_out_allowed && !reset) begin
          read_audio_in = 1'b1;
          state_nxt     = CAPTURE;
        end
      end
      CAPTURE: state_nxt = OUTPUT;
      OUTPUT: begin
        if (audio_out_allowed) begin
          write_audio_out = 1'b1;
          state_nxt       = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- capture ----------------
  // Mode and tone sum are latched with the sample so later changes cannot
  // disturb a sample already in flight.
  logic [DATA_W-1:0]       in_l_q, in_r_q;
  logic [1:0]              mode_q;
  logic signed [SUM_W-1:0] tone_q;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      in_l_q <= '0;
      in_r_q <= '0;
      mode_q <= 2'b00;
      tone_q <= '0;
    end else if (read_audio_in) begin
      in_l_q <= left_channel_audio_in;
      in_r_q <= right_channel_audio_in;
      mode_q <= mode;
      tone_q <= tone_sum;
    end
  end

  // ---------------- mix and saturate ----------------
  // Returns {saturated, value}.
  function automatic logic [DATA_W:0] saturate(input logic signed [SUM_W-1:0] x);
    if (x > SAT_MAX)      return {1'b1, MAX_DAT};
    else if (x < SAT_MIN) return {1'b1, MIN_DAT};
    else                  return {1'b0, x[DATA_W-1:0]};
  endfunction

  function automatic logic signed [SUM_W-1:0] mix(input logic [DATA_W-1:0] smp,
                                                  input logic [1:0] md,
                                                  input logic signed [SUM_W-1:0] tone);
    logic signed [SUM_W-1:0] ext;
    ext = {{(SUM_W-DATA_W){smp[DATA_W-1]}}, smp};
    case (md)
      2'b00:   return ext;
      2'b01:   return ext + tone;
      2'b10:   return tone;
      default: return '0;
    endcase
  endfunction

  logic [DATA_W:0] sat_l, sat_r;

  always_comb begin
    sat_l = saturate(mix(in_l_q, mode_q, tone_q));
    sat_r = saturate(mix(in_r_q, mode_q, tone_q));
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      left_channel_audio_out  <= '0;
      right_channel_audio_out <= '0;
    end else if (state == CAPTURE) begin
      left_channel_audio_out  <= sat_l[DATA_W-1:0];
      right_channel_audio_out <= sat_r[DATA_W-1:0];
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)                                           clip <= 1'b0;
    else if (clip_clear)                                 clip <= 1'b0;
    else if (state == CAPTURE && (sat_l[DATA_W] || sat_r[DATA_W])) clip <= 1'b1;
  end

endmodule

// File: tb/tb_audio_tone_mixer.sv
// Directed bench for audio_tone_mixer: reset, passthrough, single voice,
// saturation with clip, backpressure with mute, reset in OUTPUT, period change.
module tb_audio_tone_mixer;

  localparam int DW = 32;
  localparam int NV = 4;
  localparam int PW = 19;

  localparam logic [31:0] AMP_P = 32'h0FFFFFF0;
  localparam logic [31:0] AMP_N = 32'hF0000010;

  logic           CLOCK_50 = 1'b0;
  logic           reset;
  logic [NV*PW-1:0] period;
  logic [1:0]     mode;
  logic           clip_clear;
  logic           audio_in_available;
  logic [DW-1:0]  left_channel_audio_in;
  logic [DW-1:0]  right_channel_audio_in;
  logic           read_audio_in;
  logic           audio_out_allowed;
  logic [DW-1:0]  left_channel_audio_out;
  logic [DW-1:0]  right_channel_audio_out;
  logic           write_audio_out;
  logic           clip;

  int total  = 0;
  int passes = 0;

  audio_tone_mixer dut (
    .CLOCK_50               (CLOCK_50),
    .reset                  (reset),
    .period                 (period),
    .mode                   (mode),
    .clip_clear             (clip_clear),
    .audio_in_available     (audio_in_available),
    .left_channel_audio_in  (left_channel_audio_in),
    .right_channel_audio_in (right_channel_audio_in),
    .read_audio_in          (read_audio_in),
    .audio_out_allowed      (audio_out_allowed),
    .left_channel_audio_out (left_channel_audio_out),
    .right_channel_audio_out(right_channel_audio_out),
    .write_audio_out        (write_audio_out),
    .clip                   (clip)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Single-voice expected outputs, by read slot (reads at n = 0,3,6,...,18).
  logic [31:0] sv_exp [7] = '{AMP_N, AMP_N, AMP_P, AMP_N, AMP_P, AMP_P, AMP_N};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset with stimulus active ----------------
    reset = 1'b1; clip_clear = 1'b0; mode = 2'b00; period = '0;
    left_channel_audio_in = 32'h00001234; right_channel_audio_in = 32'hFFFFFF00;
    audio_in_available = 1'b1; audio_out_allowed = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    #1;
    chk("rst_read",  read_audio_in, 0);
    chk("rst_write", write_audio_out, 0);
    chk("rst_L",     left_channel_audio_out, 0);
    chk("rst_R",     right_channel_audio_out, 0);
    chk("rst_clip",  clip, 0);

    // ---------------- passthrough ----------------
    @(negedge CLOCK_50); reset = 1'b0; #1;
    chk("pt_first_read", read_audio_in, 1);
    @(negedge CLOCK_50); audio_in_available = 1'b0; #1;
    chk("pt_cap_read",  read_audio_in, 0);
    chk("pt_cap_write", write_audio_out, 0);
    @(negedge CLOCK_50); #1;
    chk("pt_write", write_audio_out, 1);
    chk("pt_L",     left_channel_audio_out, 32'h00001234);
    chk("pt_R",     right_channel_audio_out, 32'hFFFFFF00);
    chk("pt_clip",  clip, 0);
    @(negedge CLOCK_50); #1;
    chk("pt_write_once", write_audio_out, 0);

    // ---------------- single voice, tones only ----------------
    @(negedge CLOCK_50);
    reset = 1'b1; mode = 2'b10; period = '0; period[0 +: PW] = 19'd3;
    left_channel_audio_in = 32'h12345678; right_channel_audio_in = 32'h12345678;
    audio_in_available = 1'b1; audio_out_allowed = 1'b1;
    @(negedge CLOCK_50); reset = 1'b0; #1;
    chk("sv_read0", read_audio_in, 1);
    for (int n = 1; n <= 20; n++) begin
      @(negedge CLOCK_50);
      if (n == 19) audio_in_available = 1'b0;
      #1;
      if (n % 3 == 0 && n <= 18) chk("sv_read", read_audio_in, 1);
      if (n % 3 == 2) begin
        chk("sv_write", write_audio_out, 1);
        chk("sv_L", left_channel_audio_out, sv_exp[(n-2)/3]);
        chk("sv_R", right_channel_audio_out, sv_exp[(n-2)/3]);
      end
    end

    // ---------------- saturation ----------------
    @(negedge CLOCK_50);
    reset = 1'b1; mode = 2'b01;
    for (int v = 0; v < NV; v++) period[v*PW +: PW] = 19'd1000;
    left_channel_audio_in = 32'h7FFFFFF0; right_channel_audio_in = 32'h80000010;
    audio_in_available = 1'b1; audio_out_allowed = 1'b1;
    @(negedge CLOCK_50); reset = 1'b0; #1;
    chk("sat_read0", read_audio_in, 1);
    @(negedge CLOCK_50); audio_in_available = 1'b0;
    @(negedge CLOCK_50); #1;
    chk("sat_neg_write", write_audio_out, 1);
    chk("sat_neg_L", left_channel_audio_out, 32'h40000030);
    chk("sat_neg_R", right_channel_audio_out, 32'h80000000);
    chk("sat_neg_clip", clip, 1);
    repeat (1002) @(negedge CLOCK_50);   // now at n = 1004
    #1;
    chk("sat_clip_sticky", clip, 1);
    @(negedge CLOCK_50); audio_in_available = 1'b1; #1;   // n = 1005
    chk("sat_read1", read_audio_in, 1);
    @(negedge CLOCK_50); audio_in_available = 1'b0;
    @(negedge CLOCK_50); #1;                               // n = 1007
    chk("sat_pos_write", write_audio_out, 1);
    chk("sat_pos_L", left_channel_audio_out, 32'h7FFFFFFF);
    chk("sat_pos_R", right_channel_audio_out, 32'hBFFFFFD0);
    @(negedge CLOCK_50); clip_clear = 1'b1; #1;
    chk("clip_before_clear", clip, 1);
    @(negedge CLOCK_50); clip_clear = 1'b0; #1;
    chk("clip_cleared", clip, 0);

    // ---------------- backpressure, mode change while pending ----------------
    @(negedge CLOCK_50);
    mode = 2'b00; period = '0;
    left_channel_audio_in = 32'h11111111; right_channel_audio_in = 32'h22222222;
    audio_in_available = 1'b1; audio_out_allowed = 1'b1; #1;
    chk("bp_read", read_audio_in, 1);
    @(negedge CLOCK_50); audio_out_allowed = 1'b0; #1;
    chk("bp_cap_read", read_audio_in, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLOCK_50);
      if (i == 0) mode = 2'b11;
      #1;
      chk("bp_hold_read",  read_audio_in, 0);
      chk("bp_hold_write", write_audio_out, 0);
      chk("bp_hold_L", left_channel_audio_out, 32'h11111111);
      chk("bp_hold_R", right_channel_audio_out, 32'h22222222);
    end
    @(negedge CLOCK_50); audio_out_allowed = 1'b1; #1;
    chk("bp_write", write_audio_out, 1);
    chk("bp_write_noread", read_audio_in, 0);
    chk("bp_write_L", left_channel_audio_out, 32'h11111111);
    @(negedge CLOCK_50); #1;
    chk("bp_idle_read", read_audio_in, 1);
    chk("bp_idle_write", write_audio_out, 0);
    @(negedge CLOCK_50); audio_in_available = 1'b0;
    @(negedge CLOCK_50); #1;
    chk("mute_write", write_audio_out, 1);
    chk("mute_L", left_channel_audio_out, 0);
    chk("mute_R", right_channel_audio_out, 0);
    chk("mute_clip", clip, 0);

    // ---------------- reset while in OUTPUT ----------------
    @(negedge CLOCK_50);
    mode = 2'b10; period = '0; period[0 +: PW] = 19'd100;
    left_channel_audio_in = 32'h00000055; right_channel_audio_in = 32'h00000055;
    audio_in_available = 1'b1; audio_out_allowed = 1'b1; #1;
    chk("ro_read", read_audio_in, 1);
    @(negedge CLOCK_50); audio_in_available = 1'b0; audio_out_allowed = 1'b0;
    @(negedge CLOCK_50); reset = 1'b1; #1;
    chk("ro_write", write_audio_out, 0);
    chk("ro_L", left_channel_audio_out, 0);
    @(negedge CLOCK_50); audio_out_allowed = 1'b1; #1;
    chk("ro_rst_write", write_audio_out, 0);
    @(negedge CLOCK_50); reset = 1'b0; #1;
    chk("ro_post_write", write_audio_out, 0);
    chk("ro_post_read", read_audio_in, 0);

    // ---------------- period lowered mid-count ----------------
    for (int n = 1; n <= 65; n++) begin
      @(negedge CLOCK_50);
      if (n == 50) period[0 +: PW] = 19'd5;
      audio_in_available = (n == 51 || n == 56 || n == 59 || n == 63);
      #1;
      if (audio_in_available) chk("pc_read", read_audio_in, 1);
      if (n == 53 || n == 58 || n == 61 || n == 65) begin
        chk("pc_write", write_audio_out, 1);
        chk("pc_L", left_channel_audio_out, (n == 61) ? AMP_N : AMP_P);
        chk("pc_R", right_channel_audio_out, (n == 61) ? AMP_N : AMP_P);
      end
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
